// File: rtl/alu_4bit_if.sv
// Operand/result bundle for alu_4bit; the core keeps flat ports, so this
// bundle is for environments that want to pass the ALU bus as one object.
interface alu_4bit_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] sel;
  logic [7:0] out;

  modport master (output a, output b, output sel, input  out);
  modport slave  (input  a, input  b, input  sel, output out);
endinterface

// File: rtl/alu_4bit.sv
// 4-bit ALU with add/sub/mul/logic ops and a single registered 8-bit result.
// One-cycle latency; async active-low reset clears the result immediately.
module alu_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] sel,
  output logic [7:0] out
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_MUL   = 2'b10,
    OP_LOGIC = 2'b11
  } op_e;

  logic [7:0] w_a_ext;
  logic [7:0] w_b_ext;
  logic [7:0] w_result;
  logic [7:0] r_out;

  assign w_a_ext = {4'b0000, a};
  assign w_b_ext = {4'b0000, b};

  // 8-bit arithmetic: SUB wraps mod 256, MUL max is 0xE1 so nothing is lost
  always_comb begin
    w_result = '0;
    case (op_e'(sel))
      OP_ADD:   w_result = w_a_ext + w_b_ext;
      OP_SUB:   w_result = w_a_ext - w_b_ext;
      OP_MUL:   w_result = w_a_ext * w_b_ext;
      OP_LOGIC: w_result = {a | b, a & b};
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= w_result;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: expected results are queued at stimulus time
// and popped one cycle later when the registered output is sampled.
module tb_alu_4bit;

  logic clk;
  logic rst_n;
  alu_4bit_if bus ();

  alu_4bit dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (bus.a),
    .b    (bus.b),
    .sel  (bus.sel),
    .out  (bus.out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks;
  int unsigned passed;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] sel);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      2'd0:    r = ia + ib;
      2'd1:    r = (ia - ib + 256) % 256;
      2'd2:    r = ia * ib;
      default: r = (int'(a | b) * 16) + int'(a & b);
    endcase
    return r[7:0];
  endfunction

  task automatic test_reset();
    logic [7:0] got;
    bus.a = 4'h6; bus.b = 4'hA; bus.sel = 2'd2;
    #1 rst_n = 1'b0;
    #1 got = bus.out;
    checks++;
    if (got !== 8'h00) $display("FAIL reset_async got=%h exp=00", got);
    else passed++;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1 got = bus.out;
      checks++;
      if (got !== 8'h00) $display("FAIL reset_hold[%0d] got=%h exp=00", i, got);
      else passed++;
    end
    #2 rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_sweep(input logic [3:0] a, input logic [3:0] b,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] tbl[4];
    logic [7:0] got;
    logic [7:0] e;
    tbl[0] = e0; tbl[1] = e1; tbl[2] = e2; tbl[3] = e3;
    for (int s = 0; s < 4; s++) begin
      bus.a = a; bus.b = b; bus.sel = 2'(s);
      exp_q.push_back(tbl[s]);
      @(posedge clk); #1 got = bus.out;
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sweep_a%h_b%h_sel%0d scoreboard empty got=%h", a, b, s, got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL sweep_a%h_b%h_sel%0d got=%h exp=%h", a, b, s, got, e);
        else passed++;
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] got;
    bus.a = 4'h6; bus.b = 4'hA; bus.sel = 2'd2;
    @(posedge clk); #1 got = bus.out;
    checks++;
    if (got !== 8'h3C) $display("FAIL latency_setup got=%h exp=3c", got);
    else passed++;
    #1 bus.a = 4'hF; bus.b = 4'hF; bus.sel = 2'd0;
    #2 got = bus.out;
    checks++;
    if (got !== 8'h3C) $display("FAIL latency_hold got=%h exp=3c", got);
    else passed++;
    exp_q.push_back(8'h1E);
    @(posedge clk); #1 got = bus.out;
    checks++;
    if (got !== exp_q[0]) $display("FAIL latency_update got=%h exp=%h", got, exp_q[0]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    bus.a = 4'h6; bus.b = 4'hA; bus.sel = 2'd2;
    @(posedge clk); #1 got = bus.out;
    checks++;
    if (got !== 8'h3C) $display("FAIL rstmid_setup got=%h exp=3c", got);
    else passed++;
    // A result is pending for the next edge; reset must discard it.
    bus.a = 4'hF; bus.b = 4'h1; bus.sel = 2'd0;
    exp_q.push_back(8'h10);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 got = bus.out;
    checks++;
    if (got !== 8'h00) $display("FAIL rstmid_async got=%h exp=00", got);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 got = bus.out;
      checks++;
      if (got !== 8'h00) $display("FAIL rstmid_hold[%0d] got=%h exp=00", i, got);
      else passed++;
    end
    bus.a = 4'h3; bus.b = 4'h5; bus.sel = 2'd2;
    #2 rst_n = 1'b1;
    #1 got = bus.out;
    checks++;
    if (got !== 8'h00) $display("FAIL rstmid_release got=%h exp=00", got);
    else passed++;
    exp_q.push_back(8'h0F);
    @(posedge clk); #1 got = bus.out;
    checks++;
    if (got !== exp_q[0]) $display("FAIL rstmid_first_edge got=%h exp=%h", got, exp_q[0]);
    else passed++;
    exp_q.delete();
  endtask

  task automatic test_exhaustive();
    logic [7:0] got;
    logic [7:0] e;
    logic [3:0] ta;
    logic [3:0] tb;
    logic [1:0] ts;
    int unsigned errs;
    errs = 0;
    for (int s = 0; s < 4; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          ta = 4'(ia); tb = 4'(ib); ts = 2'(s);
          bus.a = ta; bus.b = tb; bus.sel = ts;
          exp_q.push_back(ref_model(ta, tb, ts));
          @(posedge clk); #1 got = bus.out;
          checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL exhaustive scoreboard empty a=%h b=%h sel=%0d", ta, tb, ts);
            errs++;
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              if (errs < 20)
                $display("FAIL exhaustive a=%h b=%h sel=%0d got=%h exp=%h", ta, tb, ts, got, e);
              errs++;
            end else begin
              passed++;
            end
          end
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b1;
    bus.a = '0; bus.b = '0; bus.sel = '0;
    test_reset();
    test_sweep(4'h0, 4'hF, 8'h0F, 8'hF1, 8'h00, 8'hF0);
    test_sweep(4'h6, 4'hA, 8'h10, 8'hFC, 8'h3C, 8'hE2);
    test_sweep(4'hF, 4'hF, 8'h1E, 8'h00, 8'hE1, 8'hFF);
    test_latency();
    test_reset_mid();
    test_exhaustive();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
